// File: rtl/imem_rx_if.sv
// Byte-stream handshake between a program source and the instruction boot loader.
// The source drives data/valid; the loader answers with ready.
interface imem_rx_if;
   logic [7:0] RxData;
   logic       RxValid;
   logic       RxReady;

   modport master (output RxData, output RxValid, input RxReady);
   modport slave  (input RxData, input RxValid, output RxReady);
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction RAM front end: zeroes the RAM, loads a counted big-endian word stream,
// holds the core in reset until loading finishes, then serves Instr from PC.
module imem_boot_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              Reset,
   imem_rx_if.slave          rx,
   input  logic [31:0]       PC,
   output logic [31:0]       Instr,
   output logic              CpuReset,
   output logic              Loading,
   output logic              Error,
   output logic [ADDR_W:0]   WordsLoaded
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_HDR_HI,
      S_HDR_LO,
      S_LOAD,
      S_RUN,
      S_ERROR
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_idx;
   logic [1:0]          r_bcnt;
   logic [ADDR_W:0]     r_words;
   logic [15:0]         r_n;
   logic [23:0]         r_word;
   logic [31:0]         r_mem [DEPTH];

   logic                w_rdy;
   logic                w_accept;
   logic [15:0]         w_n;
   logic                w_last_word;
   logic                w_we;
   logic [ADDR_W-1:0]   w_waddr;
   logic [31:0]         w_wdata;
   logic                w_pc_in;
   logic                w_unused;

   // Word counter stops at DEPTH; it can never legally go beyond the RAM size.
   function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
      if (v == (ADDR_W+1)'(DEPTH))
         return v;
      return v + (ADDR_W+1)'(1);
   endfunction

   assign w_n         = {r_n[15:8], rx.RxData};
   assign w_last_word = ((17'(r_words) + 17'd1) == {1'b0, r_n}) && (r_bcnt == 2'd3);
   assign w_accept    = w_rdy & rx.RxValid;
   assign rx.RxReady  = w_rdy;

   always_comb begin
      w_state_nxt = r_state;
      w_rdy       = 1'b0;
      CpuReset    = 1'b1;
      Loading     = 1'b0;
      Error       = 1'b0;
      case (r_state)
         S_CLEAR: begin
            Loading = 1'b1;
            if (r_idx == ADDR_W'(DEPTH - 1))
               w_state_nxt = S_HDR_HI;
         end
         S_HDR_HI: begin
            Loading = 1'b1;
            w_rdy   = 1'b1;
            if (rx.RxValid)
               w_state_nxt = S_HDR_LO;
         end
         S_HDR_LO: begin
            Loading = 1'b1;
            w_rdy   = 1'b1;
            if (rx.RxValid) begin
               if (w_n == 16'd0)
                  w_state_nxt = S_RUN;
               else if ({1'b0, w_n} > 17'(DEPTH))
                  w_state_nxt = S_ERROR;
               else
                  w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            Loading = 1'b1;
            w_rdy   = 1'b1;
            if (rx.RxValid && w_last_word)
               w_state_nxt = S_RUN;
         end
         S_RUN:   CpuReset = 1'b0;
         S_ERROR: Error    = 1'b1;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset)
         r_state <= S_CLEAR;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_idx   <= '0;
         r_bcnt  <= '0;
         r_words <= '0;
      end else if (r_state == S_CLEAR) begin
         r_idx   <= r_idx + ADDR_W'(1);
         r_bcnt  <= '0;
         r_words <= '0;
      end else if (w_accept && r_state == S_LOAD) begin
         r_bcnt <= r_bcnt + 2'd1;
         if (r_bcnt == 2'd3)
            r_words <= sat_inc(r_words);
      end
   end

   // Header and partial-word bytes; the shift register holds b0..b2 of the current word.
   always_ff @(posedge CLK) begin
      if (w_accept) begin
         case (r_state)
            S_HDR_HI: r_n[15:8] <= rx.RxData;
            S_HDR_LO: r_n[7:0]  <= rx.RxData;
            S_LOAD:   r_word    <= {r_word[15:0], rx.RxData};
            default:  ;
         endcase
      end
   end

   assign w_we    = !Reset && ((r_state == S_CLEAR) ||
                               (w_accept && r_state == S_LOAD && r_bcnt == 2'd3));
   assign w_waddr = (r_state == S_CLEAR) ? r_idx : r_words[ADDR_W-1:0];
   assign w_wdata = (r_state == S_CLEAR) ? 32'h0 : {r_word, rx.RxData};

   always_ff @(posedge CLK) begin
      if (w_we)
         r_mem[w_waddr] <= w_wdata;
   end

   // Fetches outside the RAM window return a nop; the byte offset in PC is ignored.
   assign w_pc_in     = (PC[31:ADDR_W+2] == '0);
   assign Instr       = w_pc_in ? r_mem[PC[ADDR_W+1:2]] : 32'h0;
   assign WordsLoaded = r_words;
   assign w_unused    = ^PC[1:0];
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: clear timing, loads, empty/oversize headers,
// mid-load reset and valid gaps, all with hand-computed expectations.
module tb_imem_boot_loader;
   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        CpuReset;
   logic        Loading;
   logic        Error;
   logic [8:0]  WordsLoaded;
   int          total = 0;
   int          bad   = 0;

   logic [7:0] prog2 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                              8'h00, 8'h00, 8'h00, 8'h00};

   imem_rx_if rx ();

   imem_boot_loader #(.ADDR_W(8)) dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .rx          (rx),
      .PC          (PC),
      .Instr       (Instr),
      .CpuReset    (CpuReset),
      .Loading     (Loading),
      .Error       (Error),
      .WordsLoaded (WordsLoaded)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_instr(input string tag, input logic [31:0] pc, input logic [31:0] exp);
      PC = pc;
      #1;
      check(tag, Instr, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      rx.RxData  = b;
      rx.RxValid = 1'b1;
      @(posedge CLK);
      #1;
      if (gap) begin
         rx.RxValid = 1'b0;
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      rx.RxValid = 1'b0;
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      repeat (256) @(posedge CLK);
      #1;
   endtask

   initial begin
      Reset      = 1'b1;
      rx.RxValid = 1'b0;
      rx.RxData  = 8'h00;
      PC         = 32'h0;

      // Reset state and clear duration
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      check("rst_cpureset", 32'(CpuReset), 32'd1);
      check("rst_rxready", 32'(rx.RxReady), 32'd0);
      check("rst_loading", 32'(Loading), 32'd1);
      check("rst_error", 32'(Error), 32'd0);
      check("rst_words", 32'(WordsLoaded), 32'd0);
      repeat (255) @(posedge CLK);
      #1;
      check("clear_255_rxready", 32'(rx.RxReady), 32'd0);
      check("clear_255_cpureset", 32'(CpuReset), 32'd1);
      @(posedge CLK);
      #1;
      check("clear_256_rxready", 32'(rx.RxReady), 32'd1);
      check("clear_mem0_zero", Instr, 32'h0);

      // Two-word program streamed back to back
      for (int i = 0; i < 9; i++) send_byte(prog2[i], 1'b0);
      check("c2_cpureset_before_last", 32'(CpuReset), 32'd1);
      check("c2_loading_before_last", 32'(Loading), 32'd1);
      send_byte(prog2[9], 1'b0);
      rx.RxValid = 1'b0;
      check("c2_cpureset_after_last", 32'(CpuReset), 32'd0);
      check("c2_loading_run", 32'(Loading), 32'd0);
      check("c2_rxready_run", 32'(rx.RxReady), 32'd0);
      check("c2_words", 32'(WordsLoaded), 32'd2);
      check_instr("c2_mem0", 32'h0, 32'h20080005);
      check_instr("c2_mem0_byteoff", 32'h3, 32'h20080005);
      check_instr("c2_mem1", 32'h4, 32'h0);
      send_byte(8'hFF, 1'b0);
      rx.RxValid = 1'b0;
      check("c2_run_ignores_bytes", 32'(WordsLoaded), 32'd2);

      // Empty program
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      rx.RxValid = 1'b0;
      check("c3_cpureset", 32'(CpuReset), 32'd0);
      check("c3_words", 32'(WordsLoaded), 32'd0);
      check_instr("c3_instr0", 32'h0, 32'h0);
      check_instr("c3_instr_top", 32'h3FC, 32'h0);

      // Oversize header latches Error until Reset
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check("c4_error", 32'(Error), 32'd1);
      check("c4_cpureset", 32'(CpuReset), 32'd1);
      check("c4_rxready", 32'(rx.RxReady), 32'd0);
      check("c4_loading", 32'(Loading), 32'd0);
      repeat (3) @(posedge CLK);
      #1;
      rx.RxValid = 1'b0;
      check("c4_error_sticky", 32'(Error), 32'd1);
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      check("c4_error_cleared", 32'(Error), 32'd0);

      // Header exactly DEPTH is accepted
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      rx.RxValid = 1'b0;
      check("n256_error", 32'(Error), 32'd0);
      check("n256_rxready", 32'(rx.RxReady), 32'd1);
      check("n256_loading", 32'(Loading), 32'd1);

      // Reset mid-word, then reload one word
      do_reset();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      rx.RxValid = 1'b0;
      check("c5_partial_words", 32'(WordsLoaded), 32'd1);
      check_instr("c5_partial_mem0", 32'h0, 32'h11223344);
      Reset = 1'b1;
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      check("c5_reset_words", 32'(WordsLoaded), 32'd0);
      check("c5_reset_loading", 32'(Loading), 32'd1);
      check("c5_reset_rxready", 32'(rx.RxReady), 32'd0);
      repeat (256) @(posedge CLK);
      #1;
      check_instr("c5_recleared_mem0", 32'h0, 32'h0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      rx.RxValid = 1'b0;
      check_instr("c5_mem0_before_write", 32'h0, 32'h0);
      send_byte(8'hDD, 1'b0);
      rx.RxValid = 1'b0;
      check_instr("c5_mem0", 32'h0, 32'hAABBCCDD);
      check_instr("c5_mem1", 32'h4, 32'h0);
      check("c5_words", 32'(WordsLoaded), 32'd1);
      check("c5_cpureset", 32'(CpuReset), 32'd0);

      // Valid gaps between every byte
      do_reset();
      for (int i = 0; i < 9; i++) send_byte(prog2[i], 1'b1);
      check("c6_gap_rxready", 32'(rx.RxReady), 32'd1);
      check("c6_gap_words", 32'(WordsLoaded), 32'd1);
      send_byte(prog2[9], 1'b1);
      check("c6_words", 32'(WordsLoaded), 32'd2);
      check("c6_cpureset", 32'(CpuReset), 32'd0);
      check_instr("c6_mem0", 32'h0, 32'h20080005);
      check_instr("c6_mem1", 32'h4, 32'h0);
      check_instr("c6_pc_out_of_range", 32'h400, 32'h0);
      check_instr("c6_mem_last", 32'h3FC, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
